ex_issue_reg: RTL and testbench

//  Decode->execute pipeline register that feeds the alu. Latches one decoded

---
 rtl/ex_issue_reg.sv | 111 +++++++++++
 tb/tb_ex_issue_reg.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_issue_reg.sv
// Decode->execute issue register: holds one decoded instruction for the alu,
// selects operand B and keeps operands current with writeback forwarding.
module ex_issue_reg #(
  parameter int n = 32
) (
  input  logic         clock,
  input  logic         nReset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [4:0]   Rs1Addr,
  input  logic [4:0]   Rs2Addr,
  input  logic [n-1:0] Rs1Data,
  input  logic [n-1:0] Rs2Data,
  input  logic [n-1:0] Imm,
  input  logic         AluSrcB,
  input  logic [3:0]   AluOpIn,
  input  logic [4:0]   RdAddrIn,
  input  logic         RegWriteIn,
  input  logic         FwdEn,
  input  logic [4:0]   FwdRd,
  input  logic [n-1:0] FwdData,
  input  logic         Flush,
  input  logic         OutReady,
  output logic         OutValid,
  output logic [3:0]   AluOp,
  output logic [n-1:0] A,
  output logic [n-1:0] B,
  output logic [n-1:0] Rs2Val,
  output logic [4:0]   RdAddr,
  output logic         RegWrite
);

  logic         valid_q;
  logic [3:0]   op_q;
  logic [n-1:0] a_q;
  logic [n-1:0] b_q;
  logic [n-1:0] rs2_q;
  logic [4:0]   rd_q;
  logic         we_q;
  logic [4:0]   rs1_idx_q;
  logic [4:0]   rs2_idx_q;
  logic         src_b_q;

  logic         fwd_ok;
  logic         in_hit1;
  logic         in_hit2;
  logic         hold_hit1;
  logic         hold_hit2;
  logic         load;
  logic [n-1:0] op1_in;
  logic [n-1:0] op2_in;

  assign InReady = !valid_q || OutReady;
  assign load    = InValid && InReady && !Flush;

  // x0 is hardwired zero, so a write to it is never forwarded
  assign fwd_ok    = FwdEn && (FwdRd != 5'd0);
  assign in_hit1   = fwd_ok && (FwdRd == Rs1Addr);
  assign in_hit2   = fwd_ok && (FwdRd == Rs2Addr);
  assign hold_hit1 = fwd_ok && (FwdRd == rs1_idx_q);
  assign hold_hit2 = fwd_ok && (FwdRd == rs2_idx_q);

  assign op1_in = in_hit1 ? FwdData : Rs1Data;
  assign op2_in = in_hit2 ? FwdData : Rs2Data;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      valid_q   <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      rs1_idx_q <= '0;
      rs2_idx_q <= '0;
      src_b_q   <= 1'b0;
    end else if (load) begin
      valid_q   <= 1'b1;
      op_q      <= AluOpIn;
      a_q       <= op1_in;
      b_q       <= AluSrcB ? Imm : op2_in;
      rs2_q     <= op2_in;
      rd_q      <= RdAddrIn;
      we_q      <= RegWriteIn;
      rs1_idx_q <= Rs1Addr;
      rs2_idx_q <= Rs2Addr;
      src_b_q   <= AluSrcB;
    end else begin
      if (Flush || OutReady)
        valid_q <= 1'b0;
      // keep held operands current while waiting downstream
      if (valid_q && hold_hit1)
        a_q <= FwdData;
      if (valid_q && hold_hit2) begin
        rs2_q <= FwdData;
        if (!src_b_q)
          b_q <= FwdData;
      end
    end
  end

  assign OutValid = valid_q;
  assign AluOp    = op_q;
  assign A        = a_q;
  assign B        = b_q;
  assign Rs2Val   = rs2_q;
  assign RdAddr   = rd_q;
  assign RegWrite = we_q && valid_q;

endmodule

// File: tb/tb_ex_issue_reg.sv
// Directed-vector bench for ex_issue_reg: load, immediate select,
// forwarding on capture and while stalled, flush and async reset.
module tb_ex_issue_reg;

  logic        clock = 1'b0;
  logic        nReset;
  logic        InValid;
  logic        InReady;
  logic [4:0]  Rs1Addr;
  logic [4:0]  Rs2Addr;
  logic [31:0] Rs1Data;
  logic [31:0] Rs2Data;
  logic [31:0] Imm;
  logic        AluSrcB;
  logic [3:0]  AluOpIn;
  logic [4:0]  RdAddrIn;
  logic        RegWriteIn;
  logic        FwdEn;
  logic [4:0]  FwdRd;
  logic [31:0] FwdData;
  logic        Flush;
  logic        OutReady;
  logic        OutValid;
  logic [3:0]  AluOp;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Rs2Val;
  logic [4:0]  RdAddr;
  logic        RegWrite;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ex_issue_reg #(.n(32)) dut (
    .clock(clock),
    .nReset(nReset),
    .InValid(InValid),
    .InReady(InReady),
    .Rs1Addr(Rs1Addr),
    .Rs2Addr(Rs2Addr),
    .Rs1Data(Rs1Data),
    .Rs2Data(Rs2Data),
    .Imm(Imm),
    .AluSrcB(AluSrcB),
    .AluOpIn(AluOpIn),
    .RdAddrIn(RdAddrIn),
    .RegWriteIn(RegWriteIn),
    .FwdEn(FwdEn),
    .FwdRd(FwdRd),
    .FwdData(FwdData),
    .Flush(Flush),
    .OutReady(OutReady),
    .OutValid(OutValid),
    .AluOp(AluOp),
    .A(A),
    .B(B),
    .Rs2Val(Rs2Val),
    .RdAddr(RdAddr),
    .RegWrite(RegWrite)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    nReset     = 1'b0;
    InValid    = 1'b1;
    Rs1Addr    = '0;
    Rs2Addr    = '0;
    Rs1Data    = 32'd55;
    Rs2Data    = 32'd66;
    Imm        = '0;
    AluSrcB    = 1'b0;
    AluOpIn    = 4'd3;
    RdAddrIn   = '0;
    RegWriteIn = 1'b1;
    FwdEn      = 1'b0;
    FwdRd      = '0;
    FwdData    = '0;
    Flush      = 1'b0;
    OutReady   = 1'b1;

    // reset held across a clock edge with InValid=1
    #12;
    chk("rst_valid", {31'd0, OutValid}, 32'd0);
    chk("rst_a", A, 32'd0);
    chk("rst_b", B, 32'd0);
    chk("rst_we", {31'd0, RegWrite}, 32'd0);
    nReset  = 1'b1;
    InValid = 1'b0;
    #1;
    chk("rst_inrdy", {31'd0, InReady}, 32'd1);

    // basic load
    Rs1Addr  = 5'd1;
    Rs2Addr  = 5'd2;
    Rs1Data  = 32'd5;
    Rs2Data  = 32'd3;
    AluOpIn  = 4'b0001;
    RdAddrIn = 5'd7;
    InValid  = 1'b1;
    step();
    chk("ld_valid", {31'd0, OutValid}, 32'd1);
    chk("ld_a", A, 32'd5);
    chk("ld_b", B, 32'd3);
    chk("ld_op", {28'd0, AluOp}, 32'd1);
    chk("ld_rd", {27'd0, RdAddr}, 32'd7);
    chk("ld_we", {31'd0, RegWrite}, 32'd1);

    // back-to-back, no bubble
    Rs1Data = 32'd10;
    AluOpIn = 4'd2;
    #1;
    chk("b2b_inrdy", {31'd0, InReady}, 32'd1);
    step();
    chk("b2b_valid", {31'd0, OutValid}, 32'd1);
    chk("b2b_a", A, 32'd10);
    chk("b2b_op", {28'd0, AluOp}, 32'd2);

    // immediate operand
    AluSrcB = 1'b1;
    Imm     = 32'hFFFF_FFFC;
    Rs2Data = 32'd7;
    step();
    chk("imm_b", B, 32'hFFFF_FFFC);
    chk("imm_rs2", Rs2Val, 32'd7);

    // forward on capture
    AluSrcB = 1'b0;
    Rs1Addr = 5'd4;
    Rs1Data = 32'd1;
    FwdEn   = 1'b1;
    FwdRd   = 5'd4;
    FwdData = 32'd99;
    step();
    chk("fwd_a", A, 32'd99);
    chk("fwd_b", B, 32'd7);

    // x0 never forwarded
    Rs1Addr = 5'd0;
    FwdRd   = 5'd0;
    step();
    chk("fwd_x0_a", A, 32'd1);

    // stall with forward into held rs2
    FwdEn    = 1'b0;
    Rs1Addr  = 5'd9;
    Rs1Data  = 32'd11;
    Rs2Addr  = 5'd6;
    Rs2Data  = 32'd8;
    step();
    chk("st_ld_b", B, 32'd8);
    OutReady = 1'b0;
    Rs2Data  = 32'd77;
    #1;
    chk("st_inrdy", {31'd0, InReady}, 32'd0);
    step();
    chk("st_c1_b", B, 32'd8);
    chk("st_c1_v", {31'd0, OutValid}, 32'd1);
    FwdEn   = 1'b1;
    FwdRd   = 5'd6;
    FwdData = 32'd42;
    step();
    FwdEn = 1'b0;
    chk("st_c3_b", B, 32'd42);
    chk("st_c3_rs2", Rs2Val, 32'd42);
    chk("st_c3_a", A, 32'd11);
    step();
    chk("st_c4_v", {31'd0, OutValid}, 32'd1);
    chk("st_c4_b", B, 32'd42);
    OutReady = 1'b1;
    InValid  = 1'b0;
    step();
    chk("drain_v", {31'd0, OutValid}, 32'd0);
    chk("drain_we", {31'd0, RegWrite}, 32'd0);
    chk("drain_b", B, 32'd42);

    // stall forward with immediate B: B keeps Imm
    AluSrcB = 1'b1;
    Imm     = 32'd5;
    Rs2Data = 32'd3;
    InValid = 1'b1;
    step();
    OutReady = 1'b0;
    FwdEn    = 1'b1;
    FwdRd    = 5'd6;
    FwdData  = 32'd50;
    step();
    FwdEn = 1'b0;
    chk("sti_b", B, 32'd5);
    chk("sti_rs2", Rs2Val, 32'd50);

    // flush beats stall and incoming load
    Flush   = 1'b1;
    Rs1Data = 32'd123;
    step();
    Flush = 1'b0;
    chk("fl_v", {31'd0, OutValid}, 32'd0);
    chk("fl_we", {31'd0, RegWrite}, 32'd0);
    chk("fl_a", A, 32'd11);
    InValid = 1'b0;
    step();
    chk("fl_stay", {31'd0, OutValid}, 32'd0);

    // async reset mid-stall drops instruction at once
    InValid = 1'b1;
    step();
    chk("ar_v1", {31'd0, OutValid}, 32'd1);
    #2;
    nReset = 1'b0;
    #1;
    chk("ar_v0", {31'd0, OutValid}, 32'd0);
    chk("ar_a", A, 32'd0);
    nReset  = 1'b1;
    InValid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
